lut3d_nbr_fetch: RTL

LUT3D_NBR_FETCH -- requirements
Module: lut3d_nbr_fetch

---
 rtl/lut3d_nbr_fetch.sv | 125 ++++++++++++
 1 files changed

// File: rtl/lut3d_nbr_fetch.sv
// Fetches the 8 corner entries of the 3D-LUT cell that contains an input pixel.
// The entries come back in neighbour order together with the per-channel fractions.
module lut3d_nbr_fetch #(
  parameter int unsigned CD = 8,
  parameter int unsigned IW = 4,
  localparam int unsigned FW = CD - IW,
  localparam int unsigned N  = (1 << IW) + 1,
  localparam int unsigned AW = $clog2(N * N * N)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CD*3-1:0]   in_pix,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [CD*3-1:0]   rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FW-1:0]     frac_r,
  output logic [FW-1:0]     frac_g,
  output logic [FW-1:0]     frac_b,
  output logic [CD*3-1:0]   pt_nbr [7:0]
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StOut} state_e;

  state_e            state_q, state_d;
  logic [2:0]        k_q;
  logic [2:0]        cap_q;
  logic              dv_q;
  logic              rd_en_q;
  logic [AW-1:0]     rd_addr_q;
  logic [AW-1:0]     base_q;
  logic [AW-1:0]     base_in;
  logic [AW-1:0]     off;
  logic [FW-1:0]     fr_q, fg_q, fb_q;
  logic [CD*3-1:0]   nbr_q [7:0];
  logic [IW-1:0]     ir, ig, ib;
  logic              accept;

  assign ir = in_pix[CD-1:FW];
  assign ig = in_pix[2*CD-1:CD+FW];
  assign ib = in_pix[3*CD-1:2*CD+FW];

  // Every operand is widened to AW before multiplying so no product is truncated.
  assign base_in = AW'(ib) * AW'(N * N) + AW'(ig) * AW'(N) + AW'(ir);

  always_comb begin
    off = AW'(k_q[0]);
    if (k_q[1]) off = off + AW'(N);
    if (k_q[2]) off = off + AW'(N * N);
  end

  assign accept = (state_q == StIdle) && in_valid;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StFetch;
      end
      StFetch: begin
        if (k_q == 3'd7) state_d = StDrain;
      end
      StDrain: begin
        // Leave once the last neighbour lands in its register.
        if (dv_q && cap_q == 3'd7) state_d = StOut;
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      k_q       <= '0;
      cap_q     <= '0;
      dv_q      <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      base_q    <= '0;
      fr_q      <= '0;
      fg_q      <= '0;
      fb_q      <= '0;
      for (int i = 0; i < 8; i++) nbr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= (state_q == StFetch);
      // Read data is valid the cycle after each strobe.
      dv_q    <= rd_en_q;
      if (state_q == StFetch) begin
        rd_addr_q <= base_q + off;
        k_q       <= k_q + 3'd1;
      end
      if (accept) begin
        base_q <= base_in;
        fr_q   <= in_pix[FW-1:0];
        fg_q   <= in_pix[CD+FW-1:CD];
        fb_q   <= in_pix[2*CD+FW-1:2*CD];
        k_q    <= '0;
        cap_q  <= '0;
      end
      if (dv_q) begin
        nbr_q[cap_q] <= rd_data;
        cap_q        <= cap_q + 3'd1;
      end
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign frac_r  = fr_q;
  assign frac_g  = fg_q;
  assign frac_b  = fb_q;
  assign pt_nbr  = nbr_q;

endmodule
